// File: rtl/fwd_pla.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pla
// Purpose  : Registered operand-forwarding decoder for the 5-stage pipeline
//            control unit. The decode-stage source fields (asel, bsel) are
//            compared against the destinations one stage ahead (csel1, EX)
//            and two stages ahead (csel2, MEM). The result is the registered
//            2-bit bypass select for the A-operand, B-operand and store-data
//            multiplexers in the execute stage.
//
//            Select codes: 00 = register file, 01 = stage-1 result,
//                          10 = stage-2 result, 11 = immediate (bf only).
//
// Build    : FWD_STAGE2_EN  defined   -> stage-2 (csel2) forwarding enabled.
//                           undefined -> only stage-1 forwarding. csel2 is
//                                        ignored and the caller stalls for
//                                        stage-2 hazards.
//
// Ports    : clk       in   clock, rising edge
//            clr       in   asynchronous active-high reset, clears outputs
//            hold      in   pipeline stall, 1 = keep outputs unchanged
//            asel      in   [RW] rs field in decode
//            bsel      in   [RW] rt field in decode
//            csel1     in   [RW] EX-stage destination, 0 = no write
//            csel2     in   [RW] MEM-stage destination, 0 = no write
//            imm       in   decode instruction uses an immediate B operand
//            af1/af0   out  A-operand bypass select
//            bf1/bf0   out  B-operand bypass select
//            df1/df0   out  store-data bypass select
//
// Revision : 1.0  initial release
// ============================================================================
module fwd_pla #(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          hold,
    input  logic [RW-1:0] asel,
    input  logic [RW-1:0] bsel,
    input  logic [RW-1:0] csel1,
    input  logic [RW-1:0] csel2,
    input  logic          imm,
    output logic          af1,
    output logic          af0,
    output logic          bf1,
    output logic          bf0,
    output logic          df1,
    output logic          df0
);

    localparam logic [1:0] C_SEL_RF   = 2'b00;
    localparam logic [1:0] C_SEL_ST1  = 2'b01;
    localparam logic [1:0] C_SEL_ST2  = 2'b10;
    localparam logic [1:0] C_SEL_IMM  = 2'b11;
    localparam logic [RW-1:0] C_REG0  = '0;

    // ------------------------------------------------------------------
    // Per-source match terms. A csel of zero means "no write", so a zero
    // destination can never produce a hit, which also keeps register 0
    // from ever forwarding.
    // ------------------------------------------------------------------
    logic w_a_hit1;
    logic w_a_hit2;
    logic w_b_hit1;
    logic w_b_hit2;

    assign w_a_hit1 = (asel == csel1) && (csel1 != C_REG0);
    assign w_b_hit1 = (bsel == csel1) && (csel1 != C_REG0);

`ifdef FWD_STAGE2_EN
    assign w_a_hit2 = (asel == csel2) && (csel2 != C_REG0);
    assign w_b_hit2 = (bsel == csel2) && (csel2 != C_REG0);
`else
    // Stage-2 forwarding is compiled out; csel2 is intentionally ignored.
    logic w_unused_csel2;
    assign w_unused_csel2 = ^csel2;
    assign w_a_hit2 = 1'b0;
    assign w_b_hit2 = 1'b0;
`endif

    // Stage 1 holds the younger result, so it wins when both stages match.
    logic [1:0] w_a_fwd;
    logic [1:0] w_b_fwd;

    always_comb begin
        w_a_fwd = C_SEL_RF;
        if (w_a_hit1) begin
            w_a_fwd = C_SEL_ST1;
        end else if (w_a_hit2) begin
            w_a_fwd = C_SEL_ST2;
        end
    end

    always_comb begin
        w_b_fwd = C_SEL_RF;
        if (w_b_hit1) begin
            w_b_fwd = C_SEL_ST1;
        end else if (w_b_hit2) begin
            w_b_fwd = C_SEL_ST2;
        end
    end

    // ------------------------------------------------------------------
    // Next-state selects. With an immediate B operand the rt field is
    // store data (or an ignored destination), so its forwarding decision
    // moves to the D path and B picks the immediate.
    // ------------------------------------------------------------------
    logic [1:0] af_d;
    logic [1:0] bf_d;
    logic [1:0] df_d;
    logic [1:0] af_q;
    logic [1:0] bf_q;
    logic [1:0] df_q;

    always_comb begin
        af_d = af_q;
        bf_d = bf_q;
        df_d = df_q;
        if (!hold) begin
            af_d = w_a_fwd;
            if (imm) begin
                bf_d = C_SEL_IMM;
                df_d = w_b_fwd;
            end else begin
                bf_d = w_b_fwd;
                df_d = C_SEL_RF;
            end
        end
    end

    // clr is asynchronous and dominates hold.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            af_q <= C_SEL_RF;
            bf_q <= C_SEL_RF;
            df_q <= C_SEL_RF;
        end else begin
            af_q <= af_d;
            bf_q <= bf_d;
            df_q <= df_d;
        end
    end

    assign af1 = af_q[1];
    assign af0 = af_q[0];
    assign bf1 = bf_q[1];
    assign bf0 = bf_q[0];
    assign df1 = df_q[1];
    assign df0 = df_q[0];

endmodule
`default_nettype wire

// File: tb/tb_fwd_pla.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_pla
// Purpose  : Self-checking directed bench for fwd_pla, followed by a short
//            random sweep against an independent forwarding model.
//            Expected stage-2 codes follow the FWD_STAGE2_EN build macro.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fwd_pla;

    localparam int RW = 5;

`ifdef FWD_STAGE2_EN
    localparam logic [1:0] C_S2 = 2'b10;
    localparam bit         C_S2_EN = 1'b1;
`else
    localparam logic [1:0] C_S2 = 2'b00;
    localparam bit         C_S2_EN = 1'b0;
`endif

    logic          clk;
    logic          clr;
    logic          hold;
    logic [RW-1:0] asel;
    logic [RW-1:0] bsel;
    logic [RW-1:0] csel1;
    logic [RW-1:0] csel2;
    logic          imm;
    logic          af1, af0, bf1, bf0, df1, df0;

    int total_cnt;
    int fail_cnt;

    fwd_pla #(.RW(RW)) u_dut (
        .clk   (clk),
        .clr   (clr),
        .hold  (hold),
        .asel  (asel),
        .bsel  (bsel),
        .csel1 (csel1),
        .csel2 (csel2),
        .imm   (imm),
        .af1   (af1),
        .af0   (af0),
        .bf1   (bf1),
        .bf0   (bf0),
        .df1   (df1),
        .df0   (df0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [1:0] ea,
                        input logic [1:0] eb, input logic [1:0] ed);
        chk({tag, ".A"}, {af1, af0}, ea);
        chk({tag, ".B"}, {bf1, bf0}, eb);
        chk({tag, ".D"}, {df1, df0}, ed);
    endtask

    // One rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input logic [RW-1:0] c1, input logic [RW-1:0] c2,
                         input logic i);
        asel = a; bsel = b; csel1 = c1; csel2 = c2; imm = i;
    endtask

    // Independent reference: priority stage 1, then stage 2, zero never hits.
    function automatic logic [1:0] ref_fwd(input logic [RW-1:0] s,
                                           input logic [RW-1:0] c1,
                                           input logic [RW-1:0] c2);
        if (s != 0 && s == c1)                  return 2'b01;
        if (C_S2_EN && s != 0 && s == c2)       return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        logic [1:0] ea, eb, ed;
        total_cnt = 0;
        fail_cnt  = 0;
        clr  = 1'b1;
        hold = 1'b0;
        drive(5'd3, 5'd3, 5'd3, 5'd3, 1'b0);
        #2;
        chk3("reset_initial", 2'b00, 2'b00, 2'b00);

        // Edges while clr is high leave outputs cleared.
        step();
        chk3("reset_held", 2'b00, 2'b00, 2'b00);

        // Release: first edge updates.
        #3 clr = 1'b0;
        drive(5'd3, 5'd0, 5'd3, 5'd0, 1'b0);
        step();
        chk("release_a", {af1, af0}, 2'b01);

        // Asynchronous clear mid-cycle with nonzero outputs.
        drive(5'd3, 5'd3, 5'd3, 5'd0, 1'b1);
        step();
        chk3("pre_clr", 2'b01, 2'b11, 2'b01);
        #3 clr = 1'b1;
        #1;
        chk3("async_clr", 2'b00, 2'b00, 2'b00);
        // clr wins over hold.
        hold = 1'b1;
        step();
        chk3("clr_over_hold", 2'b00, 2'b00, 2'b00);
        hold = 1'b0;
        #2 clr = 1'b0;

        // Stage priority.
        drive(5'd5, 5'd0, 5'd5, 5'd5, 1'b0);
        step();
        chk("prio_both", {af1, af0}, 2'b01);
        drive(5'd5, 5'd0, 5'd7, 5'd5, 1'b0);
        step();
        chk("prio_st2", {af1, af0}, C_S2);

        // Register zero never forwards.
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk3("zero_reg", 2'b00, 2'b00, 2'b00);

        // Immediate routing.
        drive(5'd0, 5'd9, 5'd4, 5'd9, 1'b1);
        step();
        chk3("imm1", 2'b00, 2'b11, C_S2);
        drive(5'd0, 5'd9, 5'd4, 5'd9, 1'b0);
        step();
        chk3("imm0", 2'b00, C_S2, 2'b00);

        // asel == bsel gets identical decisions.
        drive(5'd12, 5'd12, 5'd12, 5'd0, 1'b0);
        step();
        chk3("same_src", 2'b01, 2'b01, 2'b00);

        // Hold.
        drive(5'd3, 5'd0, 5'd3, 5'd0, 1'b0);
        step();
        chk("hold_setup", {af1, af0}, 2'b01);
        hold = 1'b1;
        asel = 5'd6;
        step();
        chk("hold_keep", {af1, af0}, 2'b01);
        step();
        chk("hold_keep2", {af1, af0}, 2'b01);
        hold = 1'b0;
        step();
        chk("hold_release", {af1, af0}, 2'b00);

        // Random sweep over a small register range to provoke hits.
        for (int n = 0; n < 300; n++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
            ea = ref_fwd(asel, csel1, csel2);
            eb = imm ? 2'b11 : ref_fwd(bsel, csel1, csel2);
            ed = imm ? ref_fwd(bsel, csel1, csel2) : 2'b00;
            step();
            chk3("sweep", ea, eb, ed);
        end

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
